// File: rtl/cal_draw_pkg.sv
// Shared calendar-draw definitions: label select constants and the
// label frame-buffer writer state encoding.
package cal_draw_pkg;

  localparam int unsigned CAL_POS_CNT = 7;

  localparam int unsigned CAL_POS_MON = 0;
  localparam int unsigned CAL_POS_TUE = 1;
  localparam int unsigned CAL_POS_WED = 2;
  localparam int unsigned CAL_POS_THU = 3;
  localparam int unsigned CAL_POS_FRI = 4;
  localparam int unsigned CAL_POS_SAT = 5;
  localparam int unsigned CAL_POS_SUN = 6;

  typedef enum logic [1:0] {
    LBL_WR_IDLE,
    LBL_WR_SCAN,
    LBL_WR_DRAIN
  } lbl_wr_state_t;

endpackage

// File: rtl/lbl_scan_cnt.sv
// Row-major x/y scan counter over x = 0..MAX_X, y = 0..MAX_Y-1 with
// synchronous clear, advance enable and a last-coordinate flag.
module lbl_scan_cnt #(
  parameter int unsigned X_W   = 12,
  parameter int unsigned Y_W   = 12,
  parameter int unsigned MAX_X = 130,
  parameter int unsigned MAX_Y = 30
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_end, y_end;

  assign x_end  = (x_q == X_W'(MAX_X));
  assign y_end  = (y_q == Y_W'(MAX_Y - 1));
  assign last_o = x_end & y_end;
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/days_lable_fb_writer.sv
// Scans a day-label rectangle through days_lable_to_pix and writes each
// returned pixel into the frame buffer at a latched base, with back-pressure.
module days_lable_fb_writer
  import cal_draw_pkg::*;
#(
  parameter int unsigned PIX_X_W   = 12,
  parameter int unsigned PIX_Y_W   = 12,
  parameter int unsigned MAX_X     = 130,
  parameter int unsigned MAX_Y     = 30,
  parameter int unsigned FB_W      = 640,
  parameter int unsigned FB_ADDR_W = 19,
  parameter int unsigned POS_W     = $clog2(CAL_POS_CNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [POS_W-1:0]     cur_pos_i,
  input  logic [PIX_X_W-1:0]   base_x_i,
  input  logic [PIX_Y_W-1:0]   base_y_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [POS_W-1:0]     cur_pos_o,
  output logic [PIX_X_W-1:0]   pos_x_o,
  output logic [PIX_Y_W-1:0]   pos_y_o,
  input  logic                 pix_i,
  output logic                 fb_we_o,
  output logic [FB_ADDR_W-1:0] fb_addr_o,
  output logic                 fb_data_o,
  input  logic                 fb_ready_i
);

  lbl_wr_state_t        state_q;
  logic [POS_W-1:0]     cur_pos_q;
  logic [PIX_X_W-1:0]   base_x_q;
  logic [PIX_Y_W-1:0]   base_y_q;
  logic                 stg_vld_q;
  logic [PIX_X_W-1:0]   stg_x_q;
  logic [PIX_Y_W-1:0]   stg_y_q;
  logic                 hold_q;
  logic                 held_q;
  logic                 done_q;

  logic [PIX_X_W-1:0]   scan_x;
  logic [PIX_Y_W-1:0]   scan_y;
  logic                 scan_last;
  logic                 start_ok;
  logic                 stall;
  logic                 issue;

  assign start_ok = (state_q == LBL_WR_IDLE) & start_i;
  assign stall    = stg_vld_q & ~fb_ready_i;
  assign issue    = (state_q == LBL_WR_SCAN) & ~stall;

  lbl_scan_cnt #(
    .X_W   (PIX_X_W),
    .Y_W   (PIX_Y_W),
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_scan_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .clr_i  (start_ok),
    .en_i   (issue),
    .x_o    (scan_x),
    .y_o    (scan_y),
    .last_o (scan_last)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= LBL_WR_IDLE;
      cur_pos_q <= '0;
      base_x_q  <= '0;
      base_y_q  <= '0;
      stg_vld_q <= 1'b0;
      stg_x_q   <= '0;
      stg_y_q   <= '0;
      hold_q    <= 1'b0;
      held_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LBL_WR_IDLE: begin
          if (start_i) begin
            cur_pos_q <= cur_pos_i;
            base_x_q  <= base_x_i;
            base_y_q  <= base_y_i;
            state_q   <= LBL_WR_SCAN;
          end
        end
        LBL_WR_SCAN: begin
          if (issue && scan_last) state_q <= LBL_WR_DRAIN;
        end
        LBL_WR_DRAIN: begin
          if (!stall) begin
            state_q <= LBL_WR_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= LBL_WR_IDLE;
      endcase

      if (!stall) begin
        stg_vld_q <= issue;
        stg_x_q   <= scan_x;
        stg_y_q   <= scan_y;
      end

      // The pixel source has already moved on to the next coordinate one
      // cycle into a stall, so its first-stall-cycle value is kept until the
      // held write is finally accepted.
      held_q <= stall;
      if (stall && !held_q) hold_q <= pix_i;
    end
  end

  assign busy_o    = (state_q != LBL_WR_IDLE);
  assign done_o    = done_q;
  assign cur_pos_o = cur_pos_q;
  assign pos_x_o   = scan_x;
  assign pos_y_o   = scan_y;
  assign fb_we_o   = stg_vld_q;
  assign fb_data_o = stg_vld_q & (held_q ? hold_q : pix_i);
  assign fb_addr_o = FB_ADDR_W'((32'(base_y_q) + 32'(stg_y_q)) * 32'(FB_W)
                                + 32'(base_x_q) + 32'(stg_x_q));

endmodule

// File: tb/tb_days_lable_fb_writer.sv
// Directed bench for days_lable_fb_writer with a behavioural stand-in for
// days_lable_to_pix (one-cycle registered lookup of a reference bitmap).
module tb_days_lable_fb_writer;

  localparam int NCOL  = 131;
  localparam int NROW  = 30;
  localparam int NPIX  = NCOL * NROW;
  localparam int TUE   = 1;
  localparam int FRI   = 4;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  cur_pos_i;
  logic [11:0] base_x_i;
  logic [11:0] base_y_i;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  cur_pos_o;
  logic [11:0] pos_x_o;
  logic [11:0] pos_y_o;
  logic        pix_i;
  logic        fb_we_o;
  logic [18:0] fb_addr_o;
  logic        fb_data_o;
  logic        fb_ready_i;

  logic        pix_reg;
  logic        rnd_pix;
  logic        rnd_pix_en;

  int n_cmp;
  int n_bad;

  int          r_writes, r_bad, r_first_we, r_done, r_stall_cyc;
  logic [18:0] r_first_addr, r_a130, r_a01;
  logic        r_first_data, r_busy1, r_busy_done;

  days_lable_fb_writer #(
    .PIX_X_W   (12),
    .PIX_Y_W   (12),
    .MAX_X     (130),
    .MAX_Y     (30),
    .FB_W      (640),
    .FB_ADDR_W (19),
    .POS_W     (3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .cur_pos_i  (cur_pos_i),
    .base_x_i   (base_x_i),
    .base_y_i   (base_y_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cur_pos_o  (cur_pos_o),
    .pos_x_o    (pos_x_o),
    .pos_y_o    (pos_y_o),
    .pix_i      (pix_i),
    .fb_we_o    (fb_we_o),
    .fb_addr_o  (fb_addr_o),
    .fb_data_o  (fb_data_o),
    .fb_ready_i (fb_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference label bitmap; column 0 is the blank left offset.
  function automatic logic golden(input int pos, input int x, input int y);
    if (x == 0) return 1'b0;
    return ((x * 3 + y + pos) % 7) < 3;
  endfunction

  always @(posedge clk) pix_reg <= golden(int'(cur_pos_o), int'(pos_x_o), int'(pos_y_o));
  assign pix_i = rnd_pix_en ? rnd_pix : pix_reg;

  // Called right after the edge that begins cycle 0 with start_i already driven.
  task automatic run_draw(input int pos, input int bx, input int by,
                          input bit do_stall, input bit disturb, input bit chain,
                          input int c_pos, input int c_bx, input int c_by);
    int cyc, k, ex, ey, stall_left;
    bit did_stall, seen_done;
    logic [18:0] ea;
    logic ed;
    cyc = 0; k = 0; stall_left = 0; did_stall = 0; seen_done = 0;
    r_bad = 0; r_first_we = -1; r_first_addr = '0; r_first_data = 1'b0;
    r_done = -1; r_busy1 = 1'b0; r_busy_done = 1'b1; r_a130 = '0; r_a01 = '0;
    r_stall_cyc = 0;
    while (!seen_done && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      start_i = 1'b0;
      if (disturb && cyc == 100) begin
        start_i = 1'b1; cur_pos_i = 3'd5; base_x_i = 12'd300; base_y_i = 12'd300;
      end
      if (cyc == 1) r_busy1 = busy_o;
      if (stall_left > 0) stall_left--;
      else fb_ready_i = 1'b1;
      if (do_stall && !did_stall && fb_we_o && k == 4 * NCOL + 57) begin
        fb_ready_i = 1'b0; stall_left = 2; did_stall = 1;
      end
      if (fb_we_o) begin
        ex = k % NCOL; ey = k / NCOL;
        ea = 19'((by + ey) * 640 + bx + ex);
        ed = golden(pos, ex, ey);
        if (r_first_we < 0) begin
          r_first_we = cyc; r_first_addr = fb_addr_o; r_first_data = fb_data_o;
        end
        if (k >= NPIX || fb_addr_o !== ea || fb_data_o !== ed) r_bad++;
        if (fb_ready_i) begin
          if (ex == 130 && ey == 0) r_a130 = fb_addr_o;
          if (ex == 0 && ey == 1) r_a01 = fb_addr_o;
          k++;
        end else begin
          r_stall_cyc++;
        end
      end
      if (done_o) begin
        seen_done = 1; r_done = cyc; r_busy_done = busy_o;
        if (chain) begin
          start_i = 1'b1; cur_pos_i = 3'(c_pos);
          base_x_i = 12'(c_bx); base_y_i = 12'(c_by);
        end
      end
    end
    r_writes = k;
  endtask

  task automatic kick(input int pos, input int bx, input int by);
    @(posedge clk); #1;
    start_i = 1'b1; cur_pos_i = 3'(pos); base_x_i = 12'(bx); base_y_i = 12'(by);
    fb_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    int nz;
    nz = 0;
    rst_i = 1'b0; rnd_pix_en = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      start_i = 1'($urandom_range(0, 1)); cur_pos_i = 3'($urandom_range(0, 6));
      base_x_i = 12'($urandom); base_y_i = 12'($urandom);
      rnd_pix = 1'($urandom_range(0, 1)); fb_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if ({busy_o, done_o, fb_we_o, fb_data_o, fb_addr_o, cur_pos_o, pos_x_o, pos_y_o} !== '0) nz++;
    end
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL reset_all_zero: nonzero cycles %0d, want 0", nz); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (fb_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", fb_we_o); end
    n_cmp++; if (fb_addr_o !== 19'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", fb_addr_o); end
    n_cmp++; if (pos_x_o !== 12'd0 || pos_y_o !== 12'd0) begin
      n_bad++; $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", pos_x_o, pos_y_o); end
    n_cmp++; if (dut.state_q !== cal_draw_pkg::LBL_WR_IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    @(posedge clk); #1;
    start_i = 1'b0; rnd_pix_en = 1'b0; fb_ready_i = 1'b1; rst_i = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nominal;
    kick(TUE, 10, 20);
    run_draw(TUE, 10, 20, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_busy1 !== 1'b1) begin n_bad++; $display("FAIL nom_busy_c1: got %b want 1", r_busy1); end
    n_cmp++; if (r_first_we !== 2) begin n_bad++; $display("FAIL nom_first_we_cycle: got %0d want 2", r_first_we); end
    n_cmp++; if (r_first_addr !== 19'd12810) begin n_bad++; $display("FAIL nom_first_addr: got %0d want 12810", r_first_addr); end
    n_cmp++; if (r_first_data !== 1'b0) begin n_bad++; $display("FAIL nom_first_data: got %b want 0", r_first_data); end
    n_cmp++; if (r_writes !== NPIX) begin n_bad++; $display("FAIL nom_writes: got %0d want %0d", r_writes, NPIX); end
    n_cmp++; if (r_bad !== 0) begin n_bad++; $display("FAIL nom_pixels: bad writes %0d want 0", r_bad); end
    n_cmp++; if (r_done !== 3932) begin n_bad++; $display("FAIL nom_done_cycle: got %0d want 3932", r_done); end
    n_cmp++; if (r_busy_done !== 1'b0) begin n_bad++; $display("FAIL nom_busy_at_done: got %b want 0", r_busy_done); end
  endtask

  task automatic test_row_wrap;
    kick(TUE, 10, 20);
    run_draw(TUE, 10, 20, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_a130 !== 19'd12940) begin n_bad++; $display("FAIL wrap_addr_130_0: got %0d want 12940", r_a130); end
    n_cmp++; if (r_a01 !== 19'd13450) begin n_bad++; $display("FAIL wrap_addr_0_1: got %0d want 13450", r_a01); end
  endtask

  task automatic test_backpressure;
    kick(TUE, 10, 20);
    run_draw(TUE, 10, 20, 1, 0, 0, 0, 0, 0);
    n_cmp++; if (r_stall_cyc !== 3) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d want 3", r_stall_cyc); end
    n_cmp++; if (r_bad !== 0) begin n_bad++; $display("FAIL bp_pixels: bad writes %0d want 0", r_bad); end
    n_cmp++; if (r_writes !== NPIX) begin n_bad++; $display("FAIL bp_writes: got %0d want %0d", r_writes, NPIX); end
    n_cmp++; if (r_done !== 3935) begin n_bad++; $display("FAIL bp_done_cycle: got %0d want 3935", r_done); end
  endtask

  task automatic test_busy_start;
    kick(TUE, 10, 20);
    run_draw(TUE, 10, 20, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (r_bad !== 0) begin n_bad++; $display("FAIL busy_start_pixels: bad writes %0d want 0", r_bad); end
    n_cmp++; if (r_writes !== NPIX) begin n_bad++; $display("FAIL busy_start_writes: got %0d want %0d", r_writes, NPIX); end
    n_cmp++; if (r_done !== 3932) begin n_bad++; $display("FAIL busy_start_done: got %0d want 3932", r_done); end
    @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL busy_start_requeued: busy %b want 0", busy_o); end
  endtask

  task automatic test_back_to_back;
    kick(TUE, 10, 20);
    run_draw(TUE, 10, 20, 0, 0, 1, FRI, 100, 200);
    n_cmp++; if (r_done !== 3932) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 3932", r_done); end
    run_draw(FRI, 100, 200, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (r_first_we !== 2) begin n_bad++; $display("FAIL b2b_first_we_cycle: got %0d want 2", r_first_we); end
    n_cmp++; if (r_first_addr !== 19'd128100) begin n_bad++; $display("FAIL b2b_first_addr: got %0d want 128100", r_first_addr); end
    n_cmp++; if (r_bad !== 0) begin n_bad++; $display("FAIL b2b_pixels: bad writes %0d want 0", r_bad); end
    n_cmp++; if (r_writes !== NPIX) begin n_bad++; $display("FAIL b2b_writes: got %0d want %0d", r_writes, NPIX); end
    n_cmp++; if (r_done !== 3932) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 3932", r_done); end
  endtask

  task automatic test_reset_mid_draw;
    int dones;
    dones = 0;
    kick(TUE, 10, 20);
    repeat (50) begin @(posedge clk); #1; start_i = 1'b0; end
    n_cmp++; if (fb_we_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_pre_we: got %b want 1", fb_we_o); end
    rst_i = 1'b0;
    #1;
    n_cmp++; if (fb_we_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we_drop: got %b want 0", fb_we_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy_o); end
    repeat (2) begin @(posedge clk); #1; if (done_o) dones++; end
    rst_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done_o || busy_o || fb_we_o) dones++; end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL mid_rst_no_done: activity cycles %0d want 0", dones); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_i = 1'b0; start_i = 1'b0; cur_pos_i = '0; base_x_i = '0; base_y_i = '0;
    fb_ready_i = 1'b1; rnd_pix = 1'b0; rnd_pix_en = 1'b0;
    test_reset();
    test_nominal();
    test_row_wrap();
    test_backpressure();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_draw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
